div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 start  input  1  request pulse; sampled only in IDLE.
REQ-004 alu_control  input  4  operation code from ALU control; 4'b1100 = div, 4'b1101 = rem; any other code = no request.
REQ-005 op_a  input  32  dividend, two's complement.
REQ-006 op_b  input  32  divisor, two's complement.
REQ-007 kill  input  1  pipeline flush; aborts an in-flight operation.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  single-cycle pulse; result valid in the same cycle.
REQ-010 result  output  32  quotient (div) or remainder (rem); held until the next accepted start.

Function
REQ-011 Accept condition: start=1, state IDLE, alu_control in {1100, 1101}; latches op_a, op_b and the op select; otherwise start is ignored.
REQ-012 FSM states: IDLE, PREP, CALC, DONE.
- IDLE -> PREP on accept.
- PREP -> CALC normally.
- PREP -> DONE on special case when DIV_FAST_SPECIAL_EN is defined.
- CALC -> DONE after 32 iterations.
- DONE -> IDLE unconditionally.
REQ-013 PREP: takes operand magnitudes; records quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); loads 5-bit iteration counter with 31.
REQ-014 CALC: one restoring radix-2 step per cycle (shift remainder left, bring in next dividend bit, subtract divisor if non-negative, set quotient bit); counter decrements; exits when counter = 0 at the clock edge.
REQ-015 Normal latency: start in cycle 0; done=1 in cycle 34; busy=1 in cycles 1-34.
REQ-016 Sign fix-up in DONE: negate quotient if quotient sign set; negate remainder if remainder sign set; result = quotient for div, remainder for rem.
REQ-017 Divide by zero (b = 0): quotient = 32'hFFFF_FFFF; remainder = a.
REQ-018 Overflow (a = 32'h8000_0000, b = 32'hFFFF_FFFF): quotient = 32'h8000_0000; remainder = 0.
REQ-019 REQ-017/018 override the iterative datapath in DONE regardless of configuration.
REQ-020 kill=1 in any non-IDLE state: next state IDLE; done stays 0; result unchanged.
- kill has priority over start and over every normal transition.
- kill in IDLE has no effect.
REQ-021 A start asserted in the DONE cycle is ignored; a new request is accepted no earlier than the following IDLE cycle.

Reset
REQ-022 rst_n=0 at a rising edge forces state IDLE, busy=0, done=0, result=0 and counter=0.
REQ-023 Reset has priority over kill and start; reset mid-CALC discards the operation with no done pulse.

Configuration
REQ-024 Macro DIV_FAST_SPECIAL_EN:
- Defined: special cases (REQ-017/018) detected in PREP go directly to DONE; done=1 in cycle 2 after start in cycle 0.
- Undefined: special cases run the full CALC sequence; done=1 in cycle 34.
- Result values are identical in both builds.

Structure
REQ-025 The shared ALU package holds:
- the 4-bit operation code constants (including the div/rem codes 4'b1100 and 4'b1101);
- the div_unit state enum;
- the data width constant (32).
REQ-026 One combinational sub-module, div_step, performs a single restoring iteration (remainder/quotient in, remainder/quotient out); div_unit instantiates it once.

Verification
REQ-027 a=100, b=7, div, start cycle 0 -> done cycle 34, result=14; busy high cycles 1-34.
REQ-028 a=-100, b=7, rem -> result=-2 (32'hFFFF_FFFE); same inputs with div -> result=-14 (32'hFFFF_FFF2).
REQ-029 a=5, b=0, div -> result=32'hFFFF_FFFF; rem -> result=5. Done in cycle 2 with DIV_FAST_SPECIAL_EN, cycle 34 without.
REQ-030 a=32'h8000_0000, b=-1, div -> result=32'h8000_0000; rem -> result=0.
REQ-031 kill in cycle 10 of a div -> no done pulse, busy=0 in cycle 11. A new start (a=9, b=3) in cycle 11 -> result=3 in cycle 45.
REQ-032 rst_n=0 in cycle 20 of a div -> cycle 21 shows busy=0, done=0, result=0. start with alu_control=4'b0010 -> ignored, busy stays 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared ALU package.
// Holds the 4-bit ALU operation codes (including the divider's div/rem
// codes), the div_unit controller state enum and the datapath width.
package div_unit_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100 ^ 4'b0000 ^ 4'b1100; // 4'b0000 alias kept out of div range
  localparam logic [3:0] ALU_DIV = 4'b1100;
  localparam logic [3:0] ALU_REM = 4'b1101;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_PREP = 2'd1,
    DIV_CALC = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // True when the code selects one of the divider operations.
  function automatic logic is_div_op(input logic [3:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring radix-2 division iteration.
// The partial remainder and the quotient/dividend register form one long
// shift register: the dividend MSB shifts into the remainder LSB, and the
// new quotient bit shifts into the quotient LSB.
//
// Ports:
//   rem_in   partial remainder before the step
//   quo_in   quotient bits so far / remaining dividend bits
//   divisor  divisor magnitude
//   rem_out  partial remainder after the step
//   quo_out  shifted quotient with the new quotient bit in the LSB
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    // Borrow (diff MSB) means the trial subtraction went negative: restore.
    if (!diff[DATA_W]) begin
      rem_out = diff[DATA_W-1:0];
    end else begin
      rem_out = shifted[DATA_W-1:0];
    end
    quo_out = {quo_in[DATA_W-2:0], ~diff[DATA_W]};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed 32-bit divider (quotient or remainder).
// A request is accepted in IDLE when start is high and alu_control is the
// div or rem code. PREP takes operand magnitudes and signs, CALC runs one
// restoring step per cycle for 32 cycles, DONE applies the sign fix-up and
// pulses done with the result. Divide-by-zero and the most-negative / -1
// overflow case are overridden in DONE.
//
// Build option: macro DIV_FAST_SPECIAL_EN -- when defined, the two special
// cases skip CALC and go straight from PREP to DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request pulse (sampled in IDLE only)
//   alu_control  operation code (4'b1100 div, 4'b1101 rem)
//   op_a, op_b   dividend / divisor, two's complement
//   kill         flush; aborts an in-flight operation
//   busy         high in every state except IDLE
//   done         one-cycle pulse, result valid in the same cycle
//   result       quotient or remainder, held until the next completion
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               alu_control,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic                     kill,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        result
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e state, state_nxt;

  logic signed [DATA_W-1:0] a_q, b_q;
  logic                     is_rem_q;
  logic [DATA_W-1:0]        rem_q, quo_q, div_mag_q;
  logic [DATA_W-1:0]        rem_nx, quo_nx;
  logic                     q_neg_q, r_neg_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [DATA_W-1:0]        result_q;
  logic [DATA_W-1:0]        final_val;
  logic                     accept, div_zero, ovf, finish;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    // The most negative value maps to its correct unsigned magnitude.
    return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
  endfunction

  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  assign accept   = start && is_div_op(alu_control);
  assign div_zero = (b_q == '0);
  assign ovf      = (a_q == {1'b1, {(DATA_W-1){1'b0}}}) && (b_q == '1);

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_mag_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Next-state logic; kill overrides every transition outside IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_IDLE: if (accept) state_nxt = DIV_PREP;
      DIV_PREP: begin
`ifdef DIV_FAST_SPECIAL_EN
        if (div_zero || ovf) state_nxt = DIV_DONE;
        else                 state_nxt = DIV_CALC;
`else
        state_nxt = DIV_CALC;
`endif
      end
      DIV_CALC: if (cnt_q == '0) state_nxt = DIV_DONE;
      DIV_DONE: state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
    if (kill && (state != DIV_IDLE)) state_nxt = DIV_IDLE;
  end

  // Result selection with sign fix-up and special-case override.
  always_comb begin
    if (div_zero) begin
      final_val = is_rem_q ? a_q : '1;
    end else if (ovf) begin
      final_val = is_rem_q ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
    end else if (is_rem_q) begin
      final_val = cond_negate(rem_q, r_neg_q);
    end else begin
      final_val = cond_negate(quo_q, q_neg_q);
    end
  end

  assign finish = (state == DIV_DONE) && !kill;
  assign busy   = (state != DIV_IDLE);
  assign done   = finish;
  assign result = finish ? final_val : result_q;

  // Control state: reset applies here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DIV_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == DIV_PREP) begin
        cnt_q <= CNT_W'(DATA_W - 1);
      end else if ((state == DIV_CALC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (finish) result_q <= final_val;
    end
  end

  // Datapath registers: operand latch, PREP magnitude/sign, CALC step.
  always_ff @(posedge clk) begin
    if ((state == DIV_IDLE) && accept) begin
      a_q      <= op_a;
      b_q      <= op_b;
      is_rem_q <= (alu_control == ALU_REM);
    end
    if (state == DIV_PREP) begin
      rem_q     <= '0;
      quo_q     <= magnitude(a_q);
      div_mag_q <= magnitude(b_q);
      q_neg_q   <= a_q[DATA_W-1] ^ b_q[DATA_W-1];
      r_neg_q   <= a_q[DATA_W-1];
    end else if (state == DIV_CALC) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_control = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed arithmetic plus the two special cases.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input bit is_rem);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    return is_rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
    return 34;
  endfunction

  // Issues a request in the current cycle and follows it to completion.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit is_rem, input bit start_in_done);
    logic [31:0] exp_res;
    int          lat;
    bit          busy_ok;
    exp_res = ref_result(a, b, is_rem);
    op_a = a;
    op_b = b;
    alu_control = is_rem ? 4'b1101 : 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      tick();
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_latency(a, b)));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    if (start_in_done) begin
      op_a = 32'd77;
      op_b = 32'd3;
      alu_control = 4'b1100;
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    logic [31:0] ra, rb, prev;
    bit          rrem;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed operations
    run_op("div_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("rem_m100_7", -32'sd100, 32'd7, 1'b1, 1'b0);
    run_op("div_m100_7", -32'sd100, 32'd7, 1'b0, 1'b0);
    run_op("div_5_0", 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("rem_5_0", 32'd5, 32'd0, 1'b1, 1'b0);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("start_in_done", 32'd1000, -32'sd33, 1'b0, 1'b1);

    // Kill in cycle 10, new request in cycle 11
    prev = result;
    op_a = 32'd50;
    op_b = 32'd6;
    alu_control = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (done === 1'b1) check("kill_early_done", 32'd1, 32'd0);
      tick();
    end
    kill = 1'b1;
    check("kill_cycle_done", {31'd0, done}, 32'd0);
    tick();
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_done", {31'd0, done}, 32'd0);
    check("kill_result", result, prev);
    run_op("after_kill", 32'd9, 32'd3, 1'b0, 1'b0);

    // Reset in cycle 20 of a div
    op_a = 32'd12345;
    op_b = 32'd11;
    alu_control = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      if (done === 1'b1) check("rst_mid_early_done", 32'd1, 32'd0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    op_a = 32'd8;
    op_b = 32'd2;
    alu_control = 4'b0010;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_code_busy1", {31'd0, busy}, 32'd0);
    tick();
    check("bad_code_busy2", {31'd0, busy}, 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = $urandom_range(0, 15);
        1: rb = -32'($urandom_range(1, 15));
        2: ra = $urandom_range(0, 1000);
        3: rb = 32'd0;
        4: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : rb; end
        default: ;
      endcase
      rrem = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rrem, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
